tdm_serializer: RTL and testbench

Parametrised time-division serializer. Cycles through NCH source channels, giving each a programmable-length slot, and shifts each enabled channel's DW-bit words onto a single serial line, one bit per clock. It is the generalised successor of the fixed 4-channel, 8-bit splitter. It adds:
- per-slot word realignment
- a load handshake toward the sources
- pause support
- output qualification and frame markers

---
 rtl/tdm_serializer.sv | 145 ++++++++++++++
 tb/tb_tdm_serializer.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tdm_serializer.sv
// tdm_serializer: NCH-channel time-division serializer, one bit per clock on a single line.
// Optional build macro TDM_SERIALIZER_PARITY_EN appends an even-parity bit to every word.
module tdm_serializer #(
   parameter int NCH       = 4,
   parameter int DW        = 8,
   parameter int SLOTW     = 8,
   parameter int MSB_FIRST = 0,
`ifdef TDM_SERIALIZER_PARITY_EN
   localparam int WL       = DW + 1
`else
   localparam int WL       = DW
`endif
) (
   input  logic                   sysclk,
   input  logic                   rst,
   input  logic                   run,
   input  logic [NCH-1:0]         ch_en,
   input  logic [NCH*SLOTW-1:0]   slot_len,
   input  logic [NCH*DW-1:0]      ch_data,
   output logic [NCH-1:0]         ch_load,
   output logic                   out,
   output logic                   out_valid,
   output logic                   frame_start,
   output logic [$clog2(NCH)-1:0] ch_id,
   output logic [SLOTW-1:0]       slot_cnt,
   output logic [$clog2(WL)-1:0]  bit_idx
);

   localparam int CHW = $clog2(NCH);
   localparam int BW  = $clog2(WL);
   localparam int VW  = 1 << BW;

   logic [DW-1:0]    data_a [NCH];
   logic [SLOTW-1:0] len_a  [NCH];

   for (genvar g = 0; g < NCH; g++) begin : g_unpack
      assign data_a[g] = ch_data[g*DW +: DW];
      assign len_a[g]  = slot_len[g*SLOTW +: SLOTW];
   end

   logic [CHW-1:0]   ch_id_q, ch_id_d, ch_nxt;
   logic [SLOTW-1:0] slot_cnt_q, slot_cnt_d;
   logic [SLOTW-1:0] term_q, term_d;
   logic [BW-1:0]    bit_idx_q, bit_idx_d;
   logic [DW-1:0]    word_q, word_d;
   logic             wen_q, wen_d;
   logic             out_q, out_d;
   logic             out_valid_q, out_valid_d;

   logic             word_start;
   logic             slot_end;
   logic             cur_en;
   logic [DW-1:0]    cur_word;
   logic [DW-1:0]    ordered;
   logic [VW-1:0]    bit_vec;

   // At a word start the word being sent is the one on ch_data right now, so
   // bit 0 leaves in the same cycle the word is captured.
   assign word_start = (bit_idx_q == '0);
   assign cur_en     = word_start ? ch_en[ch_id_q] : wen_q;
   assign cur_word   = word_start ? data_a[ch_id_q] : word_q;
   assign slot_end   = (slot_cnt_q == term_q);
   assign ch_nxt     = (ch_id_q == CHW'(NCH - 1)) ? '0 : ch_id_q + 1'b1;

   for (genvar g = 0; g < DW; g++) begin : g_order
      assign ordered[g] = (MSB_FIRST != 0) ? cur_word[DW-1-g] : cur_word[g];
   end

   always_comb begin
      bit_vec           = '0;
      bit_vec[DW-1:0]   = ordered;
`ifdef TDM_SERIALIZER_PARITY_EN
      bit_vec[DW]       = ^cur_word;
`endif
   end

   // ch_load[i] is a one-cycle strobe: ch_data[i] is taken in that cycle and the
   // source may present its next word from the following cycle; no back-pressure.
   always_comb begin
      ch_id_d     = ch_id_q;
      slot_cnt_d  = slot_cnt_q;
      term_d      = term_q;
      bit_idx_d   = bit_idx_q;
      word_d      = word_q;
      wen_d       = wen_q;
      out_d       = 1'b0;
      out_valid_d = 1'b0;
      ch_load     = '0;
      frame_start = 1'b0;

      if (run) begin
         frame_start = (ch_id_q == '0) && (slot_cnt_q == '0);

         if (word_start) begin
            wen_d = ch_en[ch_id_q];
            if (ch_en[ch_id_q]) begin
               word_d           = data_a[ch_id_q];
               ch_load[ch_id_q] = 1'b1;
            end
         end

         out_valid_d = cur_en;
         out_d       = cur_en & bit_vec[bit_idx_q];

         if (slot_end) begin
            slot_cnt_d = '0;
            ch_id_d    = ch_nxt;
            term_d     = len_a[ch_nxt];
            bit_idx_d  = '0;
         end else begin
            slot_cnt_d = slot_cnt_q + 1'b1;
            bit_idx_d  = (bit_idx_q == BW'(WL - 1)) ? '0 : bit_idx_q + 1'b1;
         end
      end
   end

   always_ff @(posedge sysclk) begin
      if (rst) begin
         ch_id_q     <= '0;
         slot_cnt_q  <= '0;
         term_q      <= len_a[0];
         bit_idx_q   <= '0;
         word_q      <= '0;
         wen_q       <= 1'b0;
         out_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         ch_id_q     <= ch_id_d;
         slot_cnt_q  <= slot_cnt_d;
         term_q      <= term_d;
         bit_idx_q   <= bit_idx_d;
         word_q      <= word_d;
         wen_q       <= wen_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out       = out_q;
   assign out_valid = out_valid_q;
   assign ch_id     = ch_id_q;
   assign slot_cnt  = slot_cnt_q;
   assign bit_idx   = bit_idx_q;

endmodule

// File: tb/tb_tdm_serializer.sv
// tb_tdm_serializer: table-driven rows, hand sequences and a randomized run against a slot/word model.
module tb_tdm_serializer;

   localparam int NCH      = 4;
   localparam int DW       = 8;
   localparam int SLOTW    = 8;
   localparam int MAIN_MSB = 0;
`ifdef TDM_SERIALIZER_PARITY_EN
   localparam int WL = DW + 1;
   localparam logic [WL-1:0] MSB_EXP = 9'h1E0;
`else
   localparam int WL = DW;
   localparam logic [WL-1:0] MSB_EXP = 8'hE0;
`endif
   localparam int CHW = $clog2(NCH);
   localparam int BW  = $clog2(WL);

   // ---------------- clock / reset / DUT ----------------
   logic                 sysclk   = 1'b0;
   logic                 rst      = 1'b1;
   logic                 run      = 1'b0;
   logic [NCH-1:0]       ch_en    = '0;
   logic [NCH*SLOTW-1:0] slot_len = '0;
   logic [NCH*DW-1:0]    ch_data  = '0;
   logic [NCH-1:0]       ch_load;
   logic                 out, out_valid, frame_start;
   logic [CHW-1:0]       ch_id;
   logic [SLOTW-1:0]     slot_cnt;
   logic [BW-1:0]        bit_idx;

   logic       run2      = 1'b1;
   logic [1:0] ch_en2    = 2'b11;
   logic [15:0] slot_len2 = {8'd3, 8'd17};
   logic [15:0] ch_data2  = {8'h00, 8'h07};
   logic [1:0] ch_load2;
   logic       out2, out_valid2, frame_start2;
   logic [0:0] ch_id2;
   logic [7:0] slot_cnt2;
   logic [BW-1:0] bit_idx2;

   always #5 sysclk = ~sysclk;

   tdm_serializer #(.NCH(NCH), .DW(DW), .SLOTW(SLOTW), .MSB_FIRST(MAIN_MSB)) u_dut (
      .sysclk(sysclk), .rst(rst), .run(run), .ch_en(ch_en), .slot_len(slot_len),
      .ch_data(ch_data), .ch_load(ch_load), .out(out), .out_valid(out_valid),
      .frame_start(frame_start), .ch_id(ch_id), .slot_cnt(slot_cnt), .bit_idx(bit_idx)
   );

   tdm_serializer #(.NCH(2), .DW(8), .SLOTW(8), .MSB_FIRST(1)) u_msb (
      .sysclk(sysclk), .rst(rst), .run(run2), .ch_en(ch_en2), .slot_len(slot_len2),
      .ch_data(ch_data2), .ch_load(ch_load2), .out(out2), .out_valid(out_valid2),
      .frame_start(frame_start2), .ch_id(ch_id2), .slot_cnt(slot_cnt2), .bit_idx(bit_idx2)
   );

   // ---------------- scoreboard / model state ----------------
   int n_tests = 0;
   int n_fail  = 0;
   logic rand_data = 1'b0;

   int            m_ch, m_pos, m_len;
   logic [DW-1:0] m_word;
   logic          m_en, exp_out, exp_valid;
   int            cnt_fs, cnt_valid;
   int            cnt_ld [NCH];

   typedef struct {
      logic [NCH*SLOTW-1:0]  lens;
      logic [NCH-1:0]        en;
      int                    ncyc;
      int                    e_fs;
      logic [NCH-1:0][15:0]  e_ld;
      int                    e_valid;
   } vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int cdiv(input int n);
      return (n + WL - 1) / WL;
   endfunction

   function automatic logic bit_of(input logic [DW-1:0] w, input int k);
      if (k < DW) return (MAIN_MSB != 0) ? w[DW-1-k] : w[k];
      return ^w;
   endfunction

   // Model: position within the slot; the bit index is that position modulo the word length.
   task automatic model_step();
      int k;
      if (rst) begin
         m_ch      = 0;
         m_pos     = 0;
         m_len     = int'(slot_len[SLOTW-1:0]) + 1;
         m_word    = '0;
         m_en      = 1'b0;
         exp_out   = 1'b0;
         exp_valid = 1'b0;
      end else if (run) begin
         k = m_pos % WL;
         if (k == 0) begin
            m_en = ch_en[m_ch];
            if (m_en) m_word = ch_data[m_ch*DW +: DW];
         end
         exp_valid = m_en;
         exp_out   = m_en & bit_of(m_word, k);
         m_pos++;
         if (m_pos == m_len) begin
            m_pos = 0;
            m_ch  = (m_ch + 1) % NCH;
            m_len = int'(slot_len[m_ch*SLOTW +: SLOTW]) + 1;
         end
      end else begin
         exp_out   = 1'b0;
         exp_valid = 1'b0;
      end
   endtask

   // One clock: compare at negedge, advance model at posedge, new random data #1 later.
   task automatic cycle();
      int             k;
      logic [NCH-1:0] e_ld;
      logic           e_fs;
      @(negedge sysclk);
      if (!rst) begin
         k    = m_pos % WL;
         e_ld = '0;
         if (run && k == 0 && ch_en[m_ch]) e_ld[m_ch] = 1'b1;
         e_fs = run && (m_ch == 0) && (m_pos == 0);
         check("per_cycle {ch_id,slot_cnt,bit_idx,ch_load,frame_start,out,out_valid}",
               {ch_id, slot_cnt, bit_idx, ch_load, frame_start, out, out_valid},
               {CHW'(m_ch), SLOTW'(m_pos), BW'(k), e_ld, e_fs, exp_out, exp_valid});
         cnt_fs    += int'(frame_start);
         cnt_valid += int'(out_valid);
         for (int i = 0; i < NCH; i++) cnt_ld[i] += int'(ch_load[i]);
      end
      @(posedge sysclk);
      model_step();
      #1;
      if (rand_data)
         for (int i = 0; i < NCH; i++) ch_data[i*DW +: DW] = DW'($urandom);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cycle();
      cycle();
      rst = 1'b0;
      cnt_fs    = 0;
      cnt_valid = 0;
      for (int i = 0; i < NCH; i++) cnt_ld[i] = 0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      vec_t             vecs [5];
      int               idx, k0;
      logic [DW-1:0]    got;
      logic [WL-1:0]    got2;
      logic             vall, found;

      // row 0: free run, two frames of 256 cycles
      vecs[0].lens = {8'd31, 8'd55, 8'd79, 8'd87}; vecs[0].en = 4'b1111;
      vecs[0].ncyc = 512; vecs[0].e_fs = 2; vecs[0].e_valid = 511;
      vecs[0].e_ld[0] = 16'(2*cdiv(88)); vecs[0].e_ld[1] = 16'(2*cdiv(80));
      vecs[0].e_ld[2] = 16'(2*cdiv(56)); vecs[0].e_ld[3] = 16'(2*cdiv(32));
      // row 1: channel 2 disabled, 2 x 56 silent cycles
      vecs[1].lens = {8'd31, 8'd55, 8'd79, 8'd87}; vecs[1].en = 4'b1011;
      vecs[1].ncyc = 512; vecs[1].e_fs = 2; vecs[1].e_valid = 399;
      vecs[1].e_ld[0] = 16'(2*cdiv(88)); vecs[1].e_ld[1] = 16'(2*cdiv(80));
      vecs[1].e_ld[2] = 16'd0;           vecs[1].e_ld[3] = 16'(2*cdiv(32));
      // row 2: truncated channel-1 slot, frame of 181
      vecs[2].lens = {8'd31, 8'd55, 8'd4, 8'd87}; vecs[2].en = 4'b1111;
      vecs[2].ncyc = 362; vecs[2].e_fs = 2; vecs[2].e_valid = 361;
      vecs[2].e_ld[0] = 16'(2*cdiv(88)); vecs[2].e_ld[1] = 16'(2*cdiv(5));
      vecs[2].e_ld[2] = 16'(2*cdiv(56)); vecs[2].e_ld[3] = 16'(2*cdiv(32));
      // row 3: all 1-cycle slots
      vecs[3].lens = '0; vecs[3].en = 4'b1111;
      vecs[3].ncyc = 40; vecs[3].e_fs = 10; vecs[3].e_valid = 39;
      vecs[3].e_ld = {16'd10, 16'd10, 16'd10, 16'd10};
      // row 4: mixed short slots, ch1/ch3 disabled, frame of 10
      vecs[4].lens = {8'd2, 8'd0, 8'd1, 8'd3}; vecs[4].en = 4'b0101;
      vecs[4].ncyc = 50; vecs[4].e_fs = 5; vecs[4].e_valid = 25;
      vecs[4].e_ld = {16'd0, 16'd5, 16'd0, 16'd5};

      for (int r = 0; r < 5; r++) begin
         slot_len  = vecs[r].lens;
         ch_en     = vecs[r].en;
         rand_data = 1'b1;
         run       = 1'b1;
         do_reset();
         for (int c = 0; c < vecs[r].ncyc; c++) cycle();
         check($sformatf("row%0d_frame_starts", r), 64'(cnt_fs), 64'(vecs[r].e_fs));
         for (int i = 0; i < NCH; i++)
            check($sformatf("row%0d_loads_ch%0d", r, i), 64'(cnt_ld[i]), 64'(vecs[r].e_ld[i]));
         check($sformatf("row%0d_valid_bits", r), 64'(cnt_valid), 64'(vecs[r].e_valid));
      end

      // first word of channel 0, with its source changing mid-word
      slot_len  = {8'd31, 8'd55, 8'd79, 8'd87};
      ch_en     = '1;
      rand_data = 1'b0;
      ch_data   = {8'h11, 8'h22, 8'h33, 8'hA5};
      do_reset();
      check("h1_reset_state", {ch_id, slot_cnt, bit_idx, out, out_valid}, '0);
      check("h1_first_load", {frame_start, ch_load}, {1'b1, 4'b0001});
      cycle();
      ch_data[DW-1:0] = 8'h3C;
      got  = '0;
      vall = 1'b1;
      for (int b = 0; b < DW; b++) begin
         got[b] = out;
         vall   = vall & out_valid;
         cycle();
      end
      check("h1_word_lsb_first", got, 8'hA5);
      check("h1_word_valid", vall, 1'b1);
      idx = 9;
      while (idx < 600 && frame_start !== 1'b1) begin
         cycle();
         idx++;
      end
      check("h1_frame_period", 64'(idx), 64'd256);

      // pause at channel-0 slot_cnt 20 for 10 cycles
      for (int c = 0; c < 20; c++) cycle();
      check("h2_before_pause", {ch_id, slot_cnt}, {2'd0, 8'd20});
      run = 1'b0;
      for (int p = 0; p < 10; p++) begin
         cycle();
         check($sformatf("h2_pause%0d", p), {slot_cnt, bit_idx, out_valid, out, ch_load, frame_start},
               {8'd20, BW'(20 % WL), 1'b0, 1'b0, 4'b0000, 1'b0});
      end
      run  = 1'b1;
      k0   = 20 % WL;
      got  = '0;
      vall = 1'b1;
      for (int j = 0; j < DW - k0; j++) begin
         cycle();
         got[j] = out;
         vall   = vall & out_valid;
      end
      check("h2_resume_bits", got, 8'h3C >> k0);
      check("h2_resume_valid", vall, 1'b1);

      // reset in the middle of channel 3's slot
      found = 1'b0;
      for (int c = 0; c < 1000 && !found; c++) begin
         if (ch_id == 2'd3 && slot_cnt == 8'd5) found = 1'b1;
         else cycle();
      end
      check("h3_reach_ch3_cnt5", found, 1'b1);
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      check("h3_after_reset", {ch_id, slot_cnt, bit_idx, out, out_valid}, '0);
      rand_data = 1'b1;
      for (int c = 0; c < 300; c++) cycle();

      // MSB-first instance: word 0x07
      do_reset();
      check("msb_first_load", ch_load2, 2'b01);
      got2 = '0;
      vall = 1'b1;
      for (int b = 0; b < WL; b++) begin
         cycle();
         got2[b] = out2;
         vall    = vall & out_valid2;
      end
      check("msb_word_bits", got2, MSB_EXP);
      check("msb_word_valid", vall, 1'b1);
      check("msb_word_period", {ch_load2, ch_id2, slot_cnt2, bit_idx2, frame_start2},
            {2'b01, 1'b0, 8'(WL), BW'(0), 1'b0});

      // randomized run: pauses, enables, slot lengths, occasional reset
      rand_data = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         run = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 7) == 0) ch_en = NCH'($urandom);
         if ($urandom_range(0, 39) == 0)
            for (int i = 0; i < NCH; i++) slot_len[i*SLOTW +: SLOTW] = SLOTW'($urandom_range(0, 20));
         rst = ($urandom_range(0, 499) == 0);
         cycle();
      end
      rst = 1'b0;
      run = 1'b1;
      for (int c = 0; c < 20; c++) cycle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      n_fail++;
      $display("FAIL watchdog: got timeout, expected end of test");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
